// File: rtl/serial_link_pkg.sv
// Shared types and widths for the serial byte link (serializer and deserializer).
package serial_link_pkg;

   localparam int unsigned SERIAL_BYTE_W = 8;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, WAIT_RX} tx_state_t;

endpackage

// File: rtl/serializador_if.sv
// Core/receiver-facing signal bundle of the serializer; clock and reset stay plain ports.
interface serializador_if #(
   parameter int unsigned DATA_WIDTH = serial_link_pkg::SERIAL_BYTE_W
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  write_in;
   logic                  status_out;
   logic                  status_in;
   logic                  data_out;
   logic                  write_out;
   logic                  idle_out;

   modport master (
      output data_in, write_in, status_in,
      input  status_out, data_out, write_out, idle_out
   );

   modport slave (
      input  data_in, write_in, status_in,
      output status_out, data_out, write_out, idle_out
   );
endinterface

// File: rtl/serializador_fifo.sv
// Byte FIFO in front of the serializer; pushes at full are dropped without touching contents.
module serializador_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4
)(
   input  logic                     clk_100KHz,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  full;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk_100KHz or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_100KHz) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/serializador.sv
// Transmit end of the serial byte link: buffers bytes and shifts them out MSB-first,
// pacing each new byte on the receiver busy flag.
module serializador
   import serial_link_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SERIAL_BYTE_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES = 3
)(
   input  logic          clk_100KHz,
   input  logic          reset,
   serializador_if.slave bus
);
   localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   tx_state_t             state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] head;
   logic [BW-1:0]         bitcnt;
   logic [GW-1:0]         gapcnt;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty;
   logic                  pop;
   logic                  data_out_r;
   logic                  write_out_r;

   serializador_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_100KHz (clk_100KHz),
      .reset      (reset),
      .push       (bus.write_in),
      .pop        (pop),
      .din        (bus.data_in),
      .dout       (head),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   assign pop            = (state == IDLE) && !fifo_empty && !bus.status_in;
   assign bus.data_out   = data_out_r;
   assign bus.write_out  = write_out_r;
   assign bus.status_out = (fifo_count == CW'(FIFO_DEPTH));
   assign bus.idle_out   = (state == IDLE) && fifo_empty;

   always_ff @(posedge clk_100KHz or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         shreg       <= '0;
         bitcnt      <= '0;
         gapcnt      <= '0;
         data_out_r  <= 1'b0;
         write_out_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  // MSB goes out now; shreg keeps the remaining bits left-aligned.
                  data_out_r  <= head[DATA_WIDTH-1];
                  shreg       <= {head[DATA_WIDTH-2:0], 1'b0};
                  write_out_r <= 1'b1;
                  bitcnt      <= BW'(1);
                  state       <= SHIFT;
               end else begin
                  data_out_r  <= 1'b0;
                  write_out_r <= 1'b0;
               end
            end
            SHIFT: begin
               if (bitcnt == LAST_BIT) begin
                  data_out_r  <= 1'b0;
                  write_out_r <= 1'b0;
                  gapcnt      <= '0;
                  state       <= GAP;
               end else begin
                  data_out_r  <= shreg[DATA_WIDTH-1];
                  shreg       <= {shreg[DATA_WIDTH-2:0], 1'b0};
                  write_out_r <= 1'b1;
                  bitcnt      <= bitcnt + 1'b1;
               end
            end
            GAP: begin
               gapcnt <= gapcnt + 1'b1;
               if (gapcnt == GAP_LAST) state <= WAIT_RX;
            end
            WAIT_RX: begin
               if (!bus.status_in) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serializador.sv
// Randomized scoreboard bench for serializador: stimulus pushes expectations, a negedge monitor checks.
module tb_serializador;
   localparam int DW      = 8;
   localparam int DEPTH   = 4;
   localparam int GAP     = 3;
   localparam int SPACING = DW + GAP + 2;

   logic clk_100KHz = 1'b0;
   logic reset;

   serializador_if #(.DATA_WIDTH(DW)) bus ();

   serializador #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk_100KHz (clk_100KHz),
      .reset      (reset),
      .bus        (bus)
   );

   always #5 clk_100KHz = ~clk_100KHz;

   int checks   = 0;
   int failures = 0;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: FIFO occupancy = accepted pushes - started bytes; bytes leave in push order.
   logic [DW-1:0] byte_q [$];
   int            start_times [$];
   int            occ        = 0;
   int            cyc        = 0;
   int            last_start = -1000;
   int            starts     = 0;
   int            nbits      = 0;
   logic          prev_wr    = 1'b0;
   logic          prev_st    = 1'b1;
   logic          prev2_st   = 1'b1;
   logic [DW-1:0] prev_din   = '0;
   logic [DW-1:0] rx_byte    = '0;
   logic [DW-1:0] cur_exp    = '0;

   always @(negedge clk_100KHz) begin
      bit start_now;
      bit ready;
      bit accepted;
      int occ_before;
      cyc++;
      if (!reset) begin
         byte_q.delete();
         occ        = 0;
         nbits      = 0;
         last_start = -1000;
         prev2_st   = 1'b1;
      end else begin
         occ_before = occ;
         start_now  = bus.write_out && (nbits == 0);
         ready      = (occ_before > 0) && !prev_st && !prev2_st && (cyc - last_start >= SPACING);
         if (ready) check("start_when_ready", int'(start_now), 1);
         if (start_now) begin
            check("start_status_in_low", int'(prev_st), 0);
            check("start_spacing", int'(cyc - last_start >= SPACING), 1);
            check("start_fifo_nonempty", int'(occ_before > 0), 1);
            last_start = cyc;
            starts++;
            start_times.push_back(cyc);
            if (byte_q.size() > 0) cur_exp = byte_q.pop_front();
            if (occ > 0) occ--;
         end
         accepted = prev_wr && (occ_before < DEPTH);
         if (accepted) begin
            occ++;
            byte_q.push_back(prev_din);
         end
         check("status_out", int'(bus.status_out), int'(occ == DEPTH));
         if (bus.write_out || occ > 0 || (cyc - last_start < SPACING - 1))
            check("idle_out_busy", int'(bus.idle_out), 0);
         else if (!prev_st)
            check("idle_out_idle", int'(bus.idle_out), 1);
         if (bus.write_out) begin
            rx_byte = {rx_byte[DW-2:0], bus.data_out};
            nbits++;
            if (nbits == DW) begin
               check("byte_out", int'(rx_byte), int'(cur_exp));
               nbits = 0;
            end
         end else begin
            if (nbits != 0) begin
               check("strobe_held_bits", nbits, DW);
               nbits = 0;
            end
            check("data_out_quiet", int'(bus.data_out), 0);
         end
      end
      prev2_st = prev_st;
      prev_st  = bus.status_in;
      prev_wr  = bus.write_in;
      prev_din = bus.data_in;
   end

   task automatic tick();
      @(posedge clk_100KHz);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] b);
      bus.data_in  = b;
      bus.write_in = 1'b1;
      tick();
      bus.write_in = 1'b0;
   endtask

   task automatic wait_wr(input string name, input logic lvl, input int budget);
      int n = 0;
      while (bus.write_out !== lvl && n < budget) begin
         tick();
         n++;
      end
      check(name, int'(n < budget), 1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (!(bus.idle_out === 1'b1 && byte_q.size() == 0 && nbits == 0) && n < budget) begin
         tick();
         n++;
      end
      check(name, int'(n < budget), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      logic [DW-1:0] t6 [4];
      t6[0] = 8'h00; t6[1] = 8'hFF; t6[2] = 8'h5A; t6[3] = 8'h81;

      reset        = 1'b0;
      bus.data_in  = '0;
      bus.write_in = 1'b0;
      bus.status_in = 1'b0;
      repeat (3) tick();
      check("rst_write_out", int'(bus.write_out), 0);
      check("rst_data_out", int'(bus.data_out), 0);
      check("rst_status_out", int'(bus.status_out), 0);
      check("rst_idle_out", int'(bus.idle_out), 1);
      #2 reset = 1'b1;
      tick();

      // T1 single byte
      push(8'hA5);
      wait_idle("t1_done", 40);

      // T2 fill while receiver busy, overflow push dropped
      bus.status_in = 1'b1;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      check("t2_full", int'(bus.status_out), 1);
      push(8'h55);
      check("t2_still_full", int'(bus.status_out), 1);
      check("t2_no_tx_while_busy", int'(bus.write_out), 0);
      bus.status_in = 1'b0;
      wait_idle("t2_done", 120);

      // T3 busy asserted during GAP holds off the next byte
      push(8'h0F);
      wait_wr("t3_start", 1'b1, 5);
      wait_wr("t3_end", 1'b0, 12);
      bus.status_in = 1'b1;
      push(8'h3C);
      repeat (19) tick();
      check("t3_held_off", int'(bus.write_out), 0);
      bus.status_in = 1'b0;
      tick();
      check("t3_release_plus1", int'(bus.write_out), 0);
      tick();
      check("t3_release_plus2", int'(bus.write_out), 1);
      wait_idle("t3_done", 40);

      // T4 reset mid-byte
      push(8'hFF);
      wait_wr("t4_start", 1'b1, 5);
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("t4_rst_write_out", int'(bus.write_out), 0);
      check("t4_rst_data_out", int'(bus.data_out), 0);
      check("t4_rst_idle_out", int'(bus.idle_out), 1);
      check("t4_rst_status_out", int'(bus.status_out), 0);
      tick(); tick();
      #2 reset = 1'b1;
      s0 = starts;
      repeat (25) tick();
      check("t4_no_resend", starts - s0, 0);

      // T5 push and pop on the same edge
      bus.status_in = 1'b1;
      push(8'h21);
      bus.data_in   = 8'h43;
      bus.write_in  = 1'b1;
      bus.status_in = 1'b0;
      tick();
      bus.write_in = 1'b0;
      check("t5_count", int'(dut.u_fifo.count), 1);
      wait_idle("t5_done", 60);
      check("t5_spacing", start_times[start_times.size()-1] - start_times[start_times.size()-2], SPACING);

      // T6 receiver-style acknowledgement after every byte
      s0 = starts;
      for (int i = 0; i < 4; i++) push(t6[i]);
      for (int i = 0; i < 4; i++) begin
         wait_wr("t6_start", 1'b1, 30);
         wait_wr("t6_end", 1'b0, 12);
         bus.status_in = 1'b1;
         repeat ($urandom_range(1, 6)) tick();
         bus.status_in = 1'b0;
      end
      wait_idle("t6_done", 60);
      check("t6_bytes", starts - s0, 4);

      // Random traffic with random receiver busy
      for (int i = 0; i < 600; i++) begin
         bus.data_in   = DW'($urandom);
         bus.write_in  = ($urandom % 3 == 0);
         bus.status_in = ($urandom % 5 == 0);
         tick();
      end
      bus.write_in  = 1'b0;
      bus.status_in = 1'b0;
      wait_idle("rand_drain", 200);

      check("scoreboard_empty", byte_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
